// File: rtl/spi_master_regs_if.sv
// CPU-side register window bundle for the SPI master: address, write data,
// transfer command and registered read data.
interface spi_master_regs_if #(
    parameter int W_REG      = 5,
    parameter int W_CPU      = 32,
    parameter int W_SPI_CTRL = 2
) ();
    logic [W_REG-1:0]      addr;
    logic [W_CPU-1:0]      wd;
    logic [W_SPI_CTRL-1:0] ctrl;
    logic [W_CPU-1:0]      data_out;

    modport master (output addr, output wd, output ctrl, input data_out);
    modport slave  (input addr, input wd, input ctrl, output data_out);
endinterface

// File: rtl/spi_master_regs.sv
// SPI master behind a coprocessor-style register window. The CPU moves frames
// through TX/RX FIFOs; a small FSM serialises them with programmable clock
// divider, CPOL/CPHA mode and automatic or manual chip select.
module spi_master_regs #(
    parameter int W_FRAME    = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int W_DIV      = 8,
    parameter int W_REG      = 5,
    parameter int W_CPU      = 32,
    parameter int W_SPI_CTRL = 2,
    parameter logic [W_SPI_CTRL-1:0] MT = W_SPI_CTRL'(1),
    parameter logic [W_SPI_CTRL-1:0] MF = W_SPI_CTRL'(2)
) (
    input  logic            clk,
    input  logic            rst,
    spi_master_regs_if.slave bus,
    output logic            sclk,
    output logic            mosi,
    input  logic            miso,
    output logic            cs_n,
    output logic            irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = $clog2(2 * W_FRAME) + 1;

    localparam logic [W_REG-1:0] A_TXDATA = W_REG'(0);
    localparam logic [W_REG-1:0] A_RXDATA = W_REG'(1);
    localparam logic [W_REG-1:0] A_STATUS = W_REG'(2);
    localparam logic [W_REG-1:0] A_CTRL   = W_REG'(3);
    localparam logic [W_REG-1:0] A_CLKDIV = W_REG'(4);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SHIFT, S_DONE} state_t;
    state_t state;

    logic [5:0]         ctrl_reg;
    logic [W_DIV-1:0]   clkdiv, div_cnt, div_lat;
    logic [EW-1:0]      edge_cnt;
    logic [W_FRAME-1:0] tx_sh, tx_sh_next, rx_sh, tx_head, rx_head;
    logic               cpha_lat, cs_auto, rx_ovf;
    logic [W_FRAME-1:0] tx_mem [FIFO_DEPTH];
    logic [W_FRAME-1:0] rx_mem [FIFO_DEPTH];
    logic [PW-1:0]      tx_wr, tx_rd, rx_wr, rx_rd;
    logic               tx_full, tx_empty, rx_full, rx_empty, busy;
    logic               en, cpol, cpha, cs_manual, cs_level, irq_en;
    logic               cpu_wr, cpu_rd, tx_push, tx_pop, rx_push, rx_pop;
    logic               rx_push_req, start_frame, half_end;
    logic [5:0]         status;
    logic [W_CPU-1:0]   rd_data, data_out_q;
    logic               unused_wd;

    assign en        = ctrl_reg[0];
    assign cpol      = ctrl_reg[1];
    assign cpha      = ctrl_reg[2];
    assign cs_manual = ctrl_reg[3];
    assign cs_level  = ctrl_reg[4];
    assign irq_en    = ctrl_reg[5];

    assign cpu_wr   = (bus.ctrl == MT);
    assign cpu_rd   = (bus.ctrl == MF);
    assign tx_empty = (tx_wr == tx_rd);
    assign rx_empty = (rx_wr == rx_rd);
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign busy     = (state != S_IDLE);

    assign start_frame = en && !tx_empty && (state == S_IDLE || state == S_DONE);
    assign tx_pop      = start_frame;
    assign tx_push     = cpu_wr && (bus.addr == A_TXDATA) && (!tx_full || tx_pop);
    assign rx_pop      = cpu_rd && (bus.addr == A_RXDATA) && !rx_empty;
    assign rx_push_req = (state == S_DONE) && (div_cnt == '0);
    assign rx_push     = rx_push_req && (!rx_full || rx_pop);
    assign half_end    = (div_cnt == div_lat);

    assign tx_head    = tx_mem[tx_rd[AW-1:0]];
    assign rx_head    = rx_mem[rx_rd[AW-1:0]];
    assign tx_sh_next = tx_sh << 1;
    assign status     = {rx_ovf, busy, rx_empty, rx_full, tx_empty, tx_full};
    assign cs_n       = cs_manual ? ~cs_level : cs_auto;
    assign bus.data_out = data_out_q;
    assign unused_wd  = ^bus.wd;

    // Read mux for the register window; unmapped addresses read as zero.
    always_comb begin
        rd_data = '0;
        case (bus.addr)
            A_RXDATA: if (!rx_empty) rd_data = W_CPU'(rx_head);
            A_STATUS: rd_data = W_CPU'(status);
            A_CTRL:   rd_data = W_CPU'(ctrl_reg);
            A_CLKDIV: rd_data = W_CPU'(clkdiv);
            default:  rd_data = '0;
        endcase
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= bus.wd[W_FRAME-1:0];
        if (rx_push) rx_mem[rx_wr[AW-1:0]] <= rx_sh;
    end

    // CPU-visible registers, FIFO pointers, overflow flag, read data and irq.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_wr      <= '0;
            tx_rd      <= '0;
            rx_wr      <= '0;
            rx_rd      <= '0;
            ctrl_reg   <= '0;
            clkdiv     <= '0;
            rx_ovf     <= 1'b0;
            data_out_q <= '0;
            irq        <= 1'b0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PW'(1);
            if (tx_pop)  tx_rd <= tx_rd + PW'(1);
            if (rx_push) rx_wr <= rx_wr + PW'(1);
            if (rx_pop)  rx_rd <= rx_rd + PW'(1);
            if (cpu_wr && bus.addr == A_CTRL)   ctrl_reg <= bus.wd[5:0];
            if (cpu_wr && bus.addr == A_CLKDIV) clkdiv   <= bus.wd[W_DIV-1:0];
            if (rx_push_req && rx_full && !rx_pop)
                rx_ovf <= 1'b1;
            else if (cpu_wr && bus.addr == A_STATUS && bus.wd[5])
                rx_ovf <= 1'b0;
            if (cpu_rd) data_out_q <= rd_data;
            irq <= irq_en & (~rx_empty | rx_ovf | (tx_empty & ~busy));
        end
    end

    // Frame sequencer: loads a frame, times half-periods and shifts bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            div_cnt  <= '0;
            div_lat  <= '0;
            cpha_lat <= 1'b0;
            edge_cnt <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            cs_auto  <= 1'b1;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
        end else if (start_frame) begin
            state    <= S_SETUP;
            tx_sh    <= tx_head;
            rx_sh    <= '0;
            div_lat  <= clkdiv;
            cpha_lat <= cpha;
            div_cnt  <= '0;
            cs_auto  <= 1'b0;
            sclk     <= cpol;
            if (!cpha) mosi <= tx_head[W_FRAME-1];
        end else begin
            case (state)
                S_IDLE: sclk <= cpol;
                S_SETUP: begin
                    if (half_end) begin
                        state    <= S_SHIFT;
                        div_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + W_DIV'(1);
                    end
                end
                S_SHIFT: begin
                    if (half_end) begin
                        div_cnt  <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EW'(1);
                        if (edge_cnt[0] == cpha_lat) begin
                            rx_sh <= W_FRAME'({rx_sh, miso});
                        end else begin
                            tx_sh <= tx_sh_next;
                            mosi  <= cpha_lat ? tx_sh[W_FRAME-1] : tx_sh_next[W_FRAME-1];
                        end
                        if (edge_cnt == EW'(2 * W_FRAME - 1)) state <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt + W_DIV'(1);
                    end
                end
                S_DONE: begin
                    if (half_end) begin
                        cs_auto <= 1'b1;
                        state   <= S_IDLE;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + W_DIV'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_regs.sv
// Directed self-checking bench for spi_master_regs: modes 0 and 3, FIFO full
// and overflow handling, interrupt, mid-frame reset and manual chip select.
module tb_spi_master_regs;
    localparam logic [1:0] C_IDLE = 2'b00;
    localparam logic [1:0] C_MT   = 2'b01;
    localparam logic [1:0] C_MF   = 2'b10;

    logic clk = 1'b0;
    logic rst;
    logic sclk, mosi, miso, cs_n, irq;
    logic miso_loop, miso_const;
    int   checks = 0;
    int   failures = 0;

    int          low_cnt, tog_cnt, min_gap, max_gap;
    logic [31:0] cap;
    logic        timed_out;

    spi_master_regs_if #(.W_REG(5), .W_CPU(32), .W_SPI_CTRL(2)) bus ();

    spi_master_regs dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .sclk (sclk),
        .mosi (mosi),
        .miso (miso),
        .cs_n (cs_n),
        .irq  (irq)
    );

    assign miso = miso_loop ? mosi : miso_const;

    // Free-running 10 ns system clock.
    always #5 clk = ~clk;

    // Safety net in case something stalls outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] c, input logic [4:0] a, input logic [31:0] d);
        bus.ctrl = c;
        bus.addr = a;
        bus.wd   = d;
        tick();
        bus.ctrl = C_IDLE;
        bus.addr = '0;
        bus.wd   = '0;
    endtask

    task automatic readCheck(input string tag, input logic [4:0] a, input logic [31:0] expected);
        applyStimulus(C_MF, a, 32'h0);
        checkOutput(tag, bus.data_out, expected);
    endtask

    // Watches the SPI pins cycle by cycle: counts cs_n-low cycles, sclk
    // toggles and gaps between toggles, and captures mosi on sclk rising.
    task automatic runMonitor(input int max_cycles, input int stop_toggles,
                              output int low_o, output int tog_o, output int min_o,
                              output int max_o, output logic [31:0] cap_o, output logic to_o);
        logic prev, seen_low, first;
        int   gap;
        prev = sclk; seen_low = 1'b0; first = 1'b1; gap = 0;
        low_o = 0; tog_o = 0; min_o = 1000000; max_o = 0; cap_o = '0; to_o = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            tick();
            gap++;
            if (cs_n === 1'b0) begin
                seen_low = 1'b1;
                low_o++;
            end
            if (sclk !== prev) begin
                tog_o++;
                if (!first) begin
                    if (gap < min_o) min_o = gap;
                    if (gap > max_o) max_o = gap;
                end
                first = 1'b0;
                gap = 0;
                if (sclk === 1'b1) cap_o = {cap_o[30:0], mosi};
                prev = sclk;
            end
            if (stop_toggles != 0 && tog_o == stop_toggles) begin
                to_o = 1'b0;
                break;
            end
            if (stop_toggles == 0 && seen_low && cs_n === 1'b1) begin
                to_o = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.ctrl = C_IDLE; bus.addr = '0; bus.wd = '0;
        miso_loop = 1'b1; miso_const = 1'b0;
        tick(); tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_data_out", bus.data_out, 32'h0);
        checkOutput("rst_sclk", {31'b0, sclk}, 32'h0);
        checkOutput("rst_mosi", {31'b0, mosi}, 32'h0);
        checkOutput("rst_cs_n", {31'b0, cs_n}, 32'h1);
        checkOutput("rst_irq", {31'b0, irq}, 32'h0);
        readCheck("rst_status", 5'd2, 32'h0000_000A);

        $display("[TB] mode 0, CLKDIV=0, loopback 0xA5");
        applyStimulus(C_MT, 5'd0, 32'h0000_00A5);
        applyStimulus(C_MT, 5'd3, 32'h0000_0001);
        runMonitor(200, 0, low_cnt, tog_cnt, min_gap, max_gap, cap, timed_out);
        checkOutput("m0_finished", {31'b0, timed_out}, 32'h0);
        checkOutput("m0_toggles", 32'(tog_cnt), 32'd16);
        checkOutput("m0_min_gap", 32'(min_gap), 32'd1);
        checkOutput("m0_max_gap", 32'(max_gap), 32'd1);
        checkOutput("m0_mosi_bits", cap, 32'h0000_00A5);
        checkOutput("m0_cs_low_cycles", 32'(low_cnt), 32'd18);
        checkOutput("m0_data_out_held", bus.data_out, 32'h0000_000A);
        readCheck("m0_rxdata", 5'd1, 32'h0000_00A5);
        readCheck("m0_status", 5'd2, 32'h0000_000A);

        $display("[TB] mode 3, CLKDIV=3, miso tied high");
        miso_loop = 1'b0; miso_const = 1'b1;
        applyStimulus(C_MT, 5'd4, 32'h0000_0003);
        applyStimulus(C_MT, 5'd3, 32'h0000_0006);
        tick();
        checkOutput("m3_sclk_idle", {31'b0, sclk}, 32'h1);
        applyStimulus(C_MT, 5'd0, 32'h0000_003C);
        applyStimulus(C_MT, 5'd3, 32'h0000_0007);
        runMonitor(400, 0, low_cnt, tog_cnt, min_gap, max_gap, cap, timed_out);
        checkOutput("m3_finished", {31'b0, timed_out}, 32'h0);
        checkOutput("m3_toggles", 32'(tog_cnt), 32'd16);
        checkOutput("m3_min_gap", 32'(min_gap), 32'd4);
        checkOutput("m3_max_gap", 32'(max_gap), 32'd4);
        checkOutput("m3_mosi_bits", cap, 32'h0000_003C);
        checkOutput("m3_cs_low_cycles", 32'(low_cnt), 32'd72);
        checkOutput("m3_sclk_end", {31'b0, sclk}, 32'h1);
        readCheck("m3_rxdata", 5'd1, 32'h0000_00FF);

        $display("[TB] TX FIFO full, back-to-back burst");
        miso_loop = 1'b1;
        applyStimulus(C_MT, 5'd3, 32'h0000_0000);
        applyStimulus(C_MT, 5'd4, 32'h0000_0000);
        for (int i = 1; i <= 4; i++) applyStimulus(C_MT, 5'd0, 32'(i * 8'h11));
        readCheck("burst_status_full", 5'd2, 32'h0000_0009);
        applyStimulus(C_MT, 5'd0, 32'h0000_0055);
        applyStimulus(C_MT, 5'd0, 32'h0000_0066);
        readCheck("burst_status_drop", 5'd2, 32'h0000_0009);
        applyStimulus(C_MT, 5'd3, 32'h0000_0001);
        runMonitor(400, 0, low_cnt, tog_cnt, min_gap, max_gap, cap, timed_out);
        checkOutput("burst_finished", {31'b0, timed_out}, 32'h0);
        checkOutput("burst_toggles", 32'(tog_cnt), 32'd64);
        checkOutput("burst_cs_low_cycles", 32'(low_cnt), 32'd72);
        checkOutput("burst_mosi_bits", cap, 32'h1122_3344);
        readCheck("burst_status_after", 5'd2, 32'h0000_0006);
        for (int i = 1; i <= 4; i++) readCheck("burst_rxdata", 5'd1, 32'(i * 8'h11));

        $display("[TB] RX overflow and irq");
        applyStimulus(C_MT, 5'd3, 32'h0000_0020);
        for (int i = 1; i <= 4; i++) applyStimulus(C_MT, 5'd0, 32'(i));
        tick();
        checkOutput("ovf_irq_idle_pending", {31'b0, irq}, 32'h0);
        applyStimulus(C_MT, 5'd3, 32'h0000_0021);
        runMonitor(400, 0, low_cnt, tog_cnt, min_gap, max_gap, cap, timed_out);
        checkOutput("ovf_burst_finished", {31'b0, timed_out}, 32'h0);
        readCheck("ovf_status_rx_full", 5'd2, 32'h0000_0006);
        checkOutput("ovf_irq_rx_data", {31'b0, irq}, 32'h1);
        applyStimulus(C_MT, 5'd0, 32'h0000_0005);
        runMonitor(200, 0, low_cnt, tog_cnt, min_gap, max_gap, cap, timed_out);
        checkOutput("ovf_fifth_finished", {31'b0, timed_out}, 32'h0);
        checkOutput("ovf_fifth_cs_low", 32'(low_cnt), 32'd18);
        readCheck("ovf_status_set", 5'd2, 32'h0000_0026);
        applyStimulus(C_MT, 5'd3, 32'h0000_0020);
        applyStimulus(C_MT, 5'd0, 32'h0000_0077);
        for (int i = 1; i <= 4; i++) readCheck("ovf_rxdata", 5'd1, 32'(i));
        tick();
        checkOutput("ovf_irq_sticky", {31'b0, irq}, 32'h1);
        applyStimulus(C_MT, 5'd2, 32'h0000_0020);
        tick();
        checkOutput("ovf_irq_cleared", {31'b0, irq}, 32'h0);
        readCheck("ovf_status_cleared", 5'd2, 32'h0000_0008);

        $display("[TB] reset in the middle of a frame");
        applyStimulus(C_MT, 5'd4, 32'h0000_0003);
        applyStimulus(C_MT, 5'd3, 32'h0000_0001);
        runMonitor(200, 5, low_cnt, tog_cnt, min_gap, max_gap, cap, timed_out);
        checkOutput("mid_reached_edge5", {31'b0, timed_out}, 32'h0);
        checkOutput("mid_sclk_before", {31'b0, sclk}, 32'h1);
        checkOutput("mid_cs_n_before", {31'b0, cs_n}, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_cs_n", {31'b0, cs_n}, 32'h1);
        checkOutput("mid_sclk", {31'b0, sclk}, 32'h0);
        checkOutput("mid_data_out", bus.data_out, 32'h0);
        checkOutput("mid_irq", {31'b0, irq}, 32'h0);
        readCheck("mid_status", 5'd2, 32'h0000_000A);
        readCheck("mid_clkdiv", 5'd4, 32'h0000_0000);

        $display("[TB] manual chip select, unmapped and empty reads");
        applyStimulus(C_MT, 5'd3, 32'h0000_0018);
        checkOutput("man_cs_n_low", {31'b0, cs_n}, 32'h0);
        readCheck("man_ctrl_readback", 5'd3, 32'h0000_0018);
        readCheck("man_addr7", 5'd7, 32'h0000_0000);
        applyStimulus(C_MT, 5'd7, 32'hFFFF_FFFF);
        readCheck("man_addr7_after_wr", 5'd7, 32'h0000_0000);
        readCheck("man_rx_empty_read", 5'd1, 32'h0000_0000);
        readCheck("man_status", 5'd2, 32'h0000_000A);
        applyStimulus(C_MT, 5'd3, 32'h0000_0008);
        checkOutput("man_cs_n_high", {31'b0, cs_n}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
